// File: rtl/biu_constants_pkg.sv
// Bus interface size and protection encodings
// shared by the core, caches and BIU.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HWORD  = 3'b001,
    WORD   = 3'b010,
    DWORD  = 3'b011,
    QWORD  = 3'b100,
    OWORD  = 3'b101,
    HOWORD = 3'b110,
    KWORD  = 3'b111
  } biu_size_t;

  typedef logic [2:0] biu_prot_t;

  localparam biu_prot_t PROT_DATA        = 3'b000;
  localparam biu_prot_t PROT_INSTRUCTION = 3'b001;
  localparam biu_prot_t PROT_PRIVILEGED  = 3'b010;
  localparam biu_prot_t PROT_SECURE      = 3'b100;

endpackage

// File: rtl/riscv_cache_pkg.sv
// Cache geometry helpers and byte-enable generation
// shared by the cache pipeline stages.
package riscv_cache_pkg;
  import biu_constants_pkg::*;

  function automatic int no_of_sets(input int size, input int block_size, input int ways);
    return size * 1024 * 8 / block_size / ways;
  endfunction

  function automatic int no_of_block_offset_bits(input int block_size);
    return $clog2(block_size / 8);
  endfunction

  function automatic int no_of_index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int no_of_tag_bits(input int plen, input int idx_bits, input int blk_bits);
    return plen - idx_bits - blk_bits;
  endfunction

  // Returns {misaligned, be[7:0]}; be is zero when misaligned
  function automatic logic [8:0] be_and_misalign(
    input biu_size_t  size,
    input logic [2:0] adr_lsbs,
    input int         xlen
  );
    logic [2:0] lsb;
    logic [7:0] be;
    logic       mis;
    lsb = (xlen == 64) ? adr_lsbs : {1'b0, adr_lsbs[1:0]};
    be  = 8'h00;
    mis = 1'b0;
    unique case (size)
      BYTE: be = 8'h01 << lsb;
      HWORD: begin
        mis = adr_lsbs[0];
        be  = 8'h03 << lsb;
      end
      WORD: begin
        mis = |adr_lsbs[1:0];
        be  = 8'h0f << lsb;
      end
      DWORD: begin
        mis = (|adr_lsbs) | (xlen != 64);
        be  = 8'hff;
      end
      default: mis = 1'b1;
    endcase
    if (mis) be = 8'h00;
    return {mis, be};
  endfunction

endpackage

// File: rtl/riscv_cache_tag_fifo.sv
// Generic DEPTH x WIDTH queue with flush and a
// per-entry bit-clear mask applied to stored and incoming data.
module riscv_cache_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] wsel;
  logic [WIDTH-1:0] keep;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign keep    = clr ? ~clr_mask : '1;

  generate
    if (DEPTH == 1) begin : g_one
      assign wsel = do_push;
      assign dout = mem[0];
    end else begin : g_ptr
      localparam int PW = $clog2(DEPTH);
      logic [PW-1:0] wr;
      logic [PW-1:0] rd;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr <= '0;
          rd <= '0;
        end else if (flush) begin
          wr <= '0;
          rd <= '0;
        end else begin
          if (do_push) wr <= (wr == PW'(DEPTH - 1)) ? '0 : wr + 1'b1;
          if (do_pop)  rd <= (rd == PW'(DEPTH - 1)) ? '0 : rd + 1'b1;
        end
      end

      for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        assign wsel[i] = do_push & (wr == PW'(i));
      end

      assign dout = mem[rd];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel[i])  mem[i] <= din & keep;
        else if (clr) mem[i] <= mem[i] & keep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/riscv_cache_tag_queue.sv
// Elastic tag stage: queues core/maintenance commands with
// byte enables between cache lookup and the hit/memory stage.
module riscv_cache_tag_queue
  import biu_constants_pkg::*;
  import riscv_cache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PLEN       = XLEN,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 2,
  localparam int SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
  localparam int BLK_OFFS_BITS = no_of_block_offset_bits(BLOCK_SIZE),
  localparam int IDX_BITS      = no_of_index_bits(SETS),
  localparam int TAG_BITS      = no_of_tag_bits(PLEN, IDX_BITS, BLK_OFFS_BITS)
) (
  input  logic                rst_ni,
  input  logic                clk_i,
  input  logic                flush_i,
  input  logic                req_i,
  input  logic                invalidate_i,
  input  logic                clean_i,
  output logic                ready_o,
  input  logic [PLEN-1:0]     phys_adr_i,
  input  biu_size_t           size_i,
  input  logic                lock_i,
  input  biu_prot_t           prot_i,
  input  logic                we_i,
  input  logic [XLEN-1:0]     d_i,
  input  logic                pagefault_i,
  input  logic                invalidate_all_blocks_i,
  output logic [TAG_BITS-1:0] core_tag_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                req_o,
  output logic                wreq_o,
  output logic                invalidate_o,
  output logic                clean_o,
  output logic [PLEN-1:0]     adr_o,
  output biu_size_t           size_o,
  output logic                lock_o,
  output biu_prot_t           prot_o,
  output logic                we_o,
  output logic                pagefault_o,
  output logic [XLEN/8-1:0]   be_o,
  output logic [XLEN-1:0]     q_o,
  output logic                misaligned_o
);

  typedef struct packed {
    logic              req;
    logic              we;
    logic              inv;
    logic              clean;
    logic [PLEN-1:0]   adr;
    biu_size_t         size;
    logic              lock;
    biu_prot_t         prot;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   d;
    logic              pagefault;
    logic              misaligned;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t     din;
  entry_t     head;
  entry_t     inv_mask;
  logic [8:0] bm;
  logic       cmd;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  assign core_tag_o = phys_adr_i[PLEN-1 -: TAG_BITS];

  assign cmd     = req_i | invalidate_i | clean_i;
  assign ready_o = ~full | ready_i;
  assign push    = cmd & ready_o & ~flush_i;
  assign valid_o = ~empty;
  assign pop     = valid_o & ready_i;

  assign bm = be_and_misalign(size_i, phys_adr_i[2:0], XLEN);

  generate
    if (XLEN < 64) begin : g_narrow
      logic unused_be;
      assign unused_be = ^bm[7:XLEN/8];
    end
  endgenerate

  always_comb begin
    din            = '0;
    din.req        = req_i;
    din.we         = we_i;
    din.inv        = invalidate_i;
    din.clean      = clean_i;
    din.adr        = phys_adr_i;
    din.size       = size_i;
    din.lock       = lock_i;
    din.prot       = prot_i;
    din.be         = bm[XLEN/8-1:0];
    din.d          = d_i;
    din.pagefault  = pagefault_i;
    din.misaligned = bm[8];
  end

  // Only the inv bit is cancelled by invalidate_all_blocks
  always_comb begin
    inv_mask     = '0;
    inv_mask.inv = 1'b1;
  end

  riscv_cache_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .rst_n    (rst_ni),
    .clk      (clk_i),
    .flush    (flush_i),
    .push     (push),
    .pop      (pop),
    .clr      (invalidate_all_blocks_i),
    .clr_mask (inv_mask),
    .din      (din),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );

  assign req_o        = valid_o & head.req;
  assign wreq_o       = req_o & head.we;
  assign invalidate_o = valid_o & head.inv;
  assign clean_o      = valid_o & head.clean;
  assign misaligned_o = valid_o & head.misaligned;

  assign adr_o       = head.adr;
  assign size_o      = head.size;
  assign lock_o      = head.lock;
  assign prot_o      = head.prot;
  assign we_o        = head.we;
  assign pagefault_o = head.pagefault;
  assign be_o        = head.be;
  assign q_o         = head.d;

endmodule

// File: tb/tb_riscv_cache_tag_queue.sv
// Scoreboard bench for riscv_cache_tag_queue: XLEN=32 queue
// with directed + random traffic, plus an XLEN=64 instance.
module tb_riscv_cache_tag_queue;
  import biu_constants_pkg::*;

  localparam int DEPTH = 2;
  localparam int TAG32 = 17;
  localparam int TAG64 = 49;

  typedef struct packed {
    logic        req, we, inv, clean, lock, pf, mis;
    logic [63:0] adr, d;
    logic [2:0]  size, prot;
    logic [7:0]  be;
  } exp_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush, req, inv, cln, lock, we, pf, inv_all, rdy_in;
  logic [31:0] adr, d;
  biu_size_t   size;
  biu_prot_t   prot;
  logic        ready, valid, req_q, wreq_q, inv_q, clean_q;
  logic        lock_q, we_q, pf_q, mis_q;
  logic [TAG32-1:0] tag;
  logic [31:0] adr_q, q_q;
  logic [3:0]  be_q;
  biu_size_t   size_q;
  biu_prot_t   prot_q;

  logic        r64, lock64, we64, pf64;
  logic [63:0] adr64, d64;
  biu_size_t   size64;
  biu_prot_t   prot64;
  logic        ready64, valid64, req64_q, wreq64_q, inv64_q, clean64_q;
  logic        lock64_q, we64_q, pf64_q, mis64_q;
  logic [TAG64-1:0] tag64;
  logic [63:0] adr64_q, q64_q;
  logic [7:0]  be64_q;
  biu_size_t   size64_q;
  biu_prot_t   prot64_q;

  riscv_cache_tag_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .rst_ni(rst_n), .clk_i(clk), .flush_i(flush), .req_i(req),
    .invalidate_i(inv), .clean_i(cln), .ready_o(ready),
    .phys_adr_i(adr), .size_i(size), .lock_i(lock), .prot_i(prot),
    .we_i(we), .d_i(d), .pagefault_i(pf),
    .invalidate_all_blocks_i(inv_all), .core_tag_o(tag),
    .valid_o(valid), .ready_i(rdy_in), .req_o(req_q), .wreq_o(wreq_q),
    .invalidate_o(inv_q), .clean_o(clean_q), .adr_o(adr_q),
    .size_o(size_q), .lock_o(lock_q), .prot_o(prot_q), .we_o(we_q),
    .pagefault_o(pf_q), .be_o(be_q), .q_o(q_q), .misaligned_o(mis_q)
  );

  riscv_cache_tag_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .rst_ni(rst_n), .clk_i(clk), .flush_i(1'b0), .req_i(r64),
    .invalidate_i(1'b0), .clean_i(1'b0), .ready_o(ready64),
    .phys_adr_i(adr64), .size_i(size64), .lock_i(lock64),
    .prot_i(prot64), .we_i(we64), .d_i(d64), .pagefault_i(pf64),
    .invalidate_all_blocks_i(1'b0), .core_tag_o(tag64),
    .valid_o(valid64), .ready_i(1'b1), .req_o(req64_q),
    .wreq_o(wreq64_q), .invalidate_o(inv64_q), .clean_o(clean64_q),
    .adr_o(adr64_q), .size_o(size64_q), .lock_o(lock64_q),
    .prot_o(prot64_q), .we_o(we64_q), .pagefault_o(pf64_q),
    .be_o(be64_q), .q_o(q64_q), .misaligned_o(mis64_q)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Access of 2**s bytes: legal only if naturally aligned and fits XLEN
  function automatic logic [8:0] ref_be(int xlen, int s, logic [63:0] a);
    int n, lanes, off;
    n     = 1 << s;
    lanes = xlen / 8;
    off   = int'(a[2:0]) % lanes;
    if (s > 3 || (xlen == 32 && s == 3) || (int'(a[6:0]) % n) != 0)
      return 9'h100;
    return {1'b0, 8'(((1 << n) - 1) << off)};
  endfunction

  function automatic exp_t mk(int xlen, logic r, logic i, logic c,
                              logic w, logic l, logic p,
                              logic [63:0] a, logic [63:0] dd,
                              logic [2:0] s, logic [2:0] pr);
    exp_t e;
    logic [8:0] bm;
    bm = ref_be(xlen, int'(s), a);
    e.req = r; e.inv = i; e.clean = c; e.we = w; e.lock = l; e.pf = p;
    e.adr = a; e.d = dd; e.size = s; e.prot = pr;
    e.mis = bm[8]; e.be = bm[7:0];
    return e;
  endfunction

  exp_t exp_q[$];
  exp_t exp64[$];

  always @(negedge clk) begin : mon32
    exp_t e;
    logic pop_m, push_m;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("valid_o", valid, exp_q.size() != 0);
      chk("ready_o", ready, (exp_q.size() < DEPTH) || rdy_in);
      chk("core_tag", tag, adr[31 -: TAG32]);
      if (valid && exp_q.size() != 0) begin
        e = exp_q[0];
        chk("flags", {req_q, wreq_q, inv_q, clean_q, lock_q, we_q, pf_q, mis_q},
            {e.req, e.req & e.we, e.inv, e.clean, e.lock, e.we, e.pf, e.mis});
        chk("adr_o", adr_q, e.adr);
        chk("size_prot", {size_q, prot_q}, {e.size, e.prot});
        chk("be_o", be_q, e.be);
        chk("q_o", q_q, e.d);
      end
      pop_m  = exp_q.size() != 0 && rdy_in;
      push_m = (req | inv | cln) && (exp_q.size() < DEPTH || rdy_in);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (inv_all) foreach (exp_q[k]) exp_q[k].inv = 1'b0;
        if (push_m) begin
          e = mk(32, req, inv, cln, we, lock, pf, {32'h0, adr}, {32'h0, d},
                 size, prot);
          if (inv_all) e.inv = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst_n) begin
      exp64.delete();
    end else begin
      chk("v64_valid", valid64, exp64.size() != 0);
      chk("v64_ready", ready64, 1'b1);
      chk("v64_tag", tag64, adr64[63 -: TAG64]);
      if (valid64 && exp64.size() != 0) begin
        e = exp64.pop_front();
        chk("v64_flags", {req64_q, wreq64_q, inv64_q, clean64_q, lock64_q,
                          we64_q, pf64_q, mis64_q},
            {e.req, e.req & e.we, 2'b00, e.lock, e.we, e.pf, e.mis});
        chk("v64_adr", adr64_q, e.adr);
        chk("v64_size_prot", {size64_q, prot64_q}, {e.size, e.prot});
        chk("v64_be", be64_q, e.be);
        chk("v64_q", q64_q, e.d);
      end
      if (r64)
        exp64.push_back(mk(64, 1'b1, 1'b0, 1'b0, we64, lock64, pf64,
                           adr64, d64, size64, prot64));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0; inv = 1'b0; cln = 1'b0;
  endtask

  task automatic set_cmd(logic r, logic i, logic c, logic w,
                         logic [31:0] a, logic [2:0] s, logic [31:0] dd);
    req = r; inv = i; cln = c; we = w; adr = a; d = dd;
    size = biu_size_t'(s);
    lock = 1'($urandom % 2);
    prot = biu_prot_t'($urandom % 8);
    pf   = 1'($urandom % 2);
  endtask

  task automatic rand64();
    r64    = ($urandom % 4) != 0;
    size64 = biu_size_t'(($urandom % 4 == 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, 3));
    adr64  = {$urandom, $urandom};
    if ($urandom % 2) adr64[2:0] = 3'b000;
    d64    = {$urandom, $urandom};
    we64   = 1'($urandom % 2);
    lock64 = 1'($urandom % 2);
    pf64   = 1'($urandom % 2);
    prot64 = biu_prot_t'($urandom % 8);
  endtask

  initial begin
    flush = 0; req = 0; inv = 0; cln = 0; lock = 0; we = 0; pf = 0;
    inv_all = 0; rdy_in = 0; adr = 0; d = 0; size = BYTE; prot = '0;
    r64 = 0; lock64 = 0; we64 = 0; pf64 = 0; adr64 = 0; d64 = 0;
    size64 = BYTE; prot64 = '0;

    step(); step();
    chk("rst_valid", valid, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_payload", {adr_q, be_q, q_q, mis_q}, '0);
    rst_n = 1'b1;
    step();

    // WORD write to 0x1004, then fill, hold a third, drain in order
    set_cmd(1, 0, 0, 1, 32'h1004, 3'd2, 32'hA5A5A5A5);
    step();
    set_cmd(1, 0, 0, 0, 32'h2001, 3'd0, 32'h11223344);
    step();
    set_cmd(1, 0, 0, 1, 32'h0003, 3'd1, 32'h55667788);
    step();
    rdy_in = 1'b1;
    step();
    idle();
    repeat (3) step();

    set_cmd(1, 0, 0, 1, 32'h0000, 3'd3, 32'hDEADBEEF);
    step();
    idle();
    step(); step();

    // flush with two queued and a simultaneous push
    rdy_in = 1'b0;
    set_cmd(1, 0, 0, 0, 32'h4000, 3'd2, 32'h1);
    step();
    set_cmd(0, 0, 1, 0, 32'h4002, 3'd1, 32'h2);
    step();
    set_cmd(1, 0, 0, 1, 32'h4004, 3'd2, 32'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    step(); step();

    // invalidate entry cancelled by invalidate_all_blocks
    set_cmd(0, 1, 0, 0, 32'h8000, 3'd2, 32'h0);
    step();
    idle();
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    step();
    rdy_in = 1'b1;
    step(); step();

    // async reset while full
    rdy_in = 1'b0;
    set_cmd(1, 0, 0, 1, 32'hC000, 3'd2, 32'hCAFE);
    step();
    set_cmd(1, 1, 1, 1, 32'hC004, 3'd2, 32'hBEEF);
    step();
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_flags", {req_q, wreq_q, inv_q, clean_q, mis_q}, '0);
    chk("arst_ready", ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    r64 = 1'b1; size64 = DWORD; adr64 = 64'h8; we64 = 1'b1;
    d64 = 64'h0123456789ABCDEF; lock64 = 0; pf64 = 0; prot64 = '0;
    step();

    for (int c = 0; c < 2000; c++) begin
      set_cmd(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
              1'($urandom % 2),
              ($urandom % 2) ? $urandom : {28'h0, 4'($urandom)},
              3'(($urandom % 4 == 0) ? $urandom_range(0, 7)
                                     : $urandom_range(0, 3)),
              $urandom);
      rdy_in  = 1'($urandom % 2);
      flush   = ($urandom % 32) == 0;
      inv_all = ($urandom % 16) == 0;
      rand64();
      step();
    end

    idle();
    flush = 1'b0; inv_all = 1'b0; rdy_in = 1'b1; r64 = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_cache_tag_queue.md
# riscv_cache_tag_queue

Elastic tag stage between the cache setup/lookup front end and the cache hit/memory stage. It captures each core request or cache-maintenance command, generates byte enables and a misalignment flag, and holds up to DEPTH commands in a queue. This lets the tag/data RAM read proceed while the downstream stage back-pressures through a valid/ready handshake instead of a global stall. It supports XLEN 32 and 64 and keeps the combinational core tag for same-cycle RAM lookup.

## Interface
- XLEN, 32, data width; 32 or 64
- PLEN, XLEN, physical address width
- SIZE, 64, cache size in KB
- BLOCK_SIZE, XLEN, cache line size in bits
- WAYS, 2, associativity
- DEPTH, 2, queue entries; at least 1
- SETS, BLK_OFFS_BITS, IDX_BITS, TAG_BITS: derived with riscv_cache_pkg functions, as in the existing cache stages
- rst_ni  in  1  asynchronous active-low reset
- clk_i  in  1  clock
- flush_i  in  1  drop all queued and incoming commands
- req_i  in  1  memory access request
- invalidate_i, clean_i  in  1  maintenance commands
- ready_o  out  1  stage accepts a command this cycle
- phys_adr_i  in  PLEN  physical address
- size_i  in  biu_size_t  access size
- lock_i  in  1  locked access
- prot_i  in  biu_prot_t  protection
- we_i  in  1  write
- d_i  in  XLEN  write data
- pagefault_i  in  1  translation fault
- invalidate_all_blocks_i  in  1  cancel pending invalidates
- core_tag_o  out  TAG_BITS  phys_adr_i[PLEN-1 -: TAG_BITS], combinational
- valid_o  out  1  head entry present
- ready_i  in  1  downstream accepts head
- req_o, wreq_o, invalidate_o, clean_o  out  1  head command flags, each gated by valid_o
- adr_o  out  PLEN  head address
- size_o  out  biu_size_t  head access size
- lock_o  out  1  head locked-access flag
- prot_o  out  biu_prot_t  head protection
- we_o  out  1  head write flag
- pagefault_o  out  1  head translation-fault flag
- be_o  out  XLEN/8  head byte enables
- q_o  out  XLEN  head write data
- misaligned_o  out  1  head access is misaligned or oversized

## Operation
- Command present: cmd = req_i | invalidate_i | clean_i.
- Push: cmd & ready_o & !flush_i. Pop: valid_o & ready_i.
- ready_o = !full | ready_i. A simultaneous push and pop while full is legal and leaves the count unchanged.
- A push stores one entry with these fields: req, we, inv, clean, adr, size, lock, prot, be, d, pagefault, misaligned.
- Byte enables use lane index lsb = adr[$clog2(XLEN/8)-1:0].
  - BYTE: 'h1<<lsb. HWORD: 'h3<<lsb. WORD: 'hf<<lsb. DWORD (XLEN=64 only): 'hff.
- Misaligned is set when any of the following holds:
  - HWORD with adr[0] set;
  - WORD with adr[1:0] non-zero;
  - DWORD with adr[2:0] non-zero;
  - DWORD when XLEN=32;
  - any other size encoding.
- When misaligned is set, be is stored as 0.
- Output flags: req_o = valid_o & head.req; wreq_o = req_o & head.we; invalidate_o = valid_o & head.inv; clean_o = valid_o & head.clean.
- flush_i: count and pointers clear at the next edge and valid_o=0. Any push in the same cycle is discarded, regardless of ready_o.
- invalidate_all_blocks_i: clears the inv bit of every stored entry and of an entry pushed in the same cycle. Other fields are unaffected. An entry whose only bit was inv stays queued, with all flags 0, and pops normally.
- Pointers are $clog2(DEPTH)-bit and wrap modulo DEPTH; DEPTH=1 uses no pointers. The count is $clog2(DEPTH+1) bits.

## Timing
- Reset: valid_o, req_o, wreq_o, invalidate_o, clean_o, misaligned_o = 0. ready_o = 1. Storage, adr_o, be_o, q_o, and other payload outputs = 0.
- Latency: a command pushed at edge N is visible on the outputs after edge N (valid_o=1 in cycle N+1) when the queue was empty. There is no combinational path from inputs to head outputs.
- ready_o depends combinationally on ready_i only. core_tag_o depends combinationally on phys_adr_i only.
- A head entry stays stable until popped. Flush overrides pop.
- Reset asserted mid-operation empties the queue immediately (asynchronous).

## Structure
- Size encodings come from biu_constants_pkg. No new package types are needed.
- Add to riscv_cache_pkg: be_and_misalign(size, adr_lsbs, XLEN) returning {misaligned, be}.
- Sub-module riscv_cache_tag_fifo: generic DEPTH x WIDTH queue with push, pop, flush, full, empty and a per-entry clear mask for inv.
- The top-level module packs and unpacks the entry and computes the flags.

## Test plan
- Reset, then push req WORD to 0x1004 with we=1 and d=0xA5A5A5A5 → next cycle valid_o=1, wreq_o=1, be_o=4'b1111, adr_o=0x1004, q_o=0xA5A5A5A5, misaligned_o=0.
- DEPTH=2, ready_i=0, three back-to-back pushes (third held by the driver until accepted) → ready_o=0 after two pushes. Raise ready_i → pop and push in the same cycle, and entries drain in order.
- XLEN=32: HWORD to 0x3 → misaligned_o=1, be_o=0. DWORD to 0x0 → misaligned_o=1. XLEN=64: DWORD to 0x8 → be_o=8'hFF.
- Two entries queued, then flush_i together with push → next cycle valid_o=0 and count 0. The pushed command never appears.
- Queue an invalidate entry, then pulse invalidate_all_blocks_i → invalidate_o=0 on that entry, which still pops on ready_i.
- Assert rst_ni low while the queue is full → all flags 0 and ready_o=1 immediately.
